// File: rtl/button_event_arbiter_if.sv
// Event stream between the button arbiter and the main FSM.
// The master presents evt_code qualified by evt_valid; the slave accepts with evt_ready.
interface button_event_arbiter_if #(
  parameter int CODE_W = 2
) ();
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that turns debounced button pulses into a single
// valid/ready event stream. Each channel holds at most one pending event;
// an edge arriving while its channel is still pending is reported on overrun.

// One channel: its pending flag and its sticky overrun flag.
module button_event_lane (
  input  logic clk,
  input  logic reset,
  input  logic rise,
  input  logic load,
  input  logic clr_overrun,
  output logic pending,
  output logic overrun
);
  // A fresh edge wins over the load that empties the slot, so it becomes the next event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pending <= 1'b0;
    else if (rise) pending <= 1'b1;
    else if (load) pending <= 1'b0;
  end

  // An edge hitting a slot that is still occupied is lost; setting beats clearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        overrun <= 1'b0;
    else if (rise && pending && !load) overrun <= 1'b1;
    else if (clr_overrun)              overrun <= 1'b0;
  end
endmodule

module button_event_arbiter #(
  parameter int N_REQ  = 4,
  parameter int CODE_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_REQ-1:0]      req_in,
  input  logic                  clr_overrun,
  output logic [N_REQ-1:0]      overrun,
  button_event_arbiter_if.master evt
);
  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]    req_q;
  logic [N_REQ-1:0]    rise;
  logic [N_REQ-1:0]    pending;
  logic [N_REQ-1:0]    load_vec;
  logic [CODE_W-1:0]   win_idx;
  logic [CODE_W-1:0]   ptr_nxt;
  logic                any_pend;
  logic                load;

  // Rising edges are only taken while enabled; req_q keeps tracking regardless.
  assign rise = req_in & ~req_q & {N_REQ{enable}};

  // Edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) req_q <= '0;
    else        req_q <= req_in;
  end

  // Round-robin pick from rr_ptr upward; scanning downward lets the nearest hit win.
  always_comb begin
    int j;
    any_pend = 1'b0;
    win_idx  = '0;
    j        = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (pending[j]) begin
        any_pend = 1'b1;
        win_idx  = CODE_W'(j);
      end
    end
  end

  assign ptr_nxt = (win_idx == CODE_W'(N_REQ - 1)) ? '0 : win_idx + CODE_W'(1);

  // Per-channel slots.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign load_vec[gi] = load && (win_idx == CODE_W'(gi));
      button_event_lane u_lane (
        .clk         (clk),
        .reset       (reset),
        .rise        (rise[gi]),
        .load        (load_vec[gi]),
        .clr_overrun (clr_overrun),
        .pending     (pending[gi]),
        .overrun     (overrun[gi])
      );
    end
  endgenerate

  // State register plus the presented code and the arbitration pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        code_q <= win_idx;
        rr_ptr <= ptr_nxt;
      end
    end
  end

  // Next state: load when the output slot is empty or is being consumed this cycle.
  always_comb begin
    load    = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (evt.evt_ready) begin
          if (any_pend) load = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    evt.evt_valid = (state_q == PRESENT);
    evt.evt_code  = code_q;
  end
endmodule
